// File: rtl/rx_ber_monitor.sv
// Bit-error-rate monitor: recovers an oversampled serial stream, locks onto a repeating
// reference pattern, counts mismatching bits and reports the pass percentage as two bytes.
module rx_ber_monitor #(
  parameter int OSR   = 10,
  parameter int PAT_W = 8,
  parameter int CNT_W = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rx_bit_data_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [CNT_W-1:0] max_rx_count_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             rx_started_flag_o,
  output logic             bit_valid_o,
  output logic             bit_data_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [7:0]       to_uart_data_o,
  output logic             to_uart_valid_o,
  input  logic             to_uart_ready_i
);

  localparam int PH_W  = $clog2(OSR);
  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int NUM_W = CNT_W + 7;
  localparam int DC_W  = $clog2(NUM_W);
  localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(OSR / 2);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OSR - 1);
  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(PAT_W - 1);
  localparam logic [DC_W-1:0]  DIV_LAST = DC_W'(NUM_W - 1);
  localparam logic [7:0]       HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    HUNT,
    CHECK,
    DIVIDE,
    SEND_HDR,
    SEND_PCT
  } state_t;

  logic            sync1_q, sync2_q, prevSample_q;
  logic [PH_W-1:0] phase_q, phase_d;
  logic            bitValid_q, bitData_q;
  logic            edgeSeen;

  assign edgeSeen = sync2_q ^ prevSample_q;

  always_comb begin
    phase_d = phase_q + PH_W'(1);
    if (edgeSeen) begin
      phase_d = PH_W'(1);
    end else if (phase_q == PH_LAST) begin
      phase_d = '0;
    end
  end

  // Recovery never stops; each sample lands OSR/2 cycles after the last observed edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      prevSample_q <= 1'b0;
      phase_q      <= '0;
      bitValid_q   <= 1'b0;
      bitData_q    <= 1'b0;
    end else begin
      sync1_q      <= rx_bit_data_i;
      sync2_q      <= sync1_q;
      prevSample_q <= sync2_q;
      phase_q      <= phase_d;
      bitValid_q   <= (phase_q == PH_HALF);
      if (phase_q == PH_HALF) begin
        bitData_q <= sync2_q;
      end
    end
  end

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   patLatch_q, patLatch_d;
  logic [PAT_W-1:0]   shift_q, shift_d, shiftNext;
  logic [CNT_W-1:0]   maxCnt_q, maxCnt_d;
  logic [CNT_W-1:0]   errCnt_q, errCnt_d;
  logic [CNT_W-1:0]   bitCnt_q, bitCnt_d;
  logic [IDX_W-1:0]   expIdx_q, expIdx_d;
  logic [NUM_W-1:0]   quot_q, quot_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [DC_W-1:0]    divCnt_q, divCnt_d;
  logic [CNT_W-1:0]   passCnt;
  logic [NUM_W-1:0]   numerator;
  logic [CNT_W:0]     remShift;

  assign passCnt   = maxCnt_q - errCnt_q;
  assign numerator = {7'd0, passCnt} * NUM_W'(100);
  assign remShift  = {rem_q, quot_q[NUM_W-1]};

  // The quotient register starts out holding the dividend and shifts result bits in as it empties.
  always_comb begin
    state_d    = state_q;
    patLatch_d = patLatch_q;
    shift_d    = shift_q;
    shiftNext  = {shift_q[PAT_W-2:0], bitData_q};
    maxCnt_d   = maxCnt_q;
    errCnt_d   = errCnt_q;
    bitCnt_d   = bitCnt_q;
    expIdx_d   = expIdx_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    divCnt_d   = divCnt_q;
    case (state_q)
      IDLE: begin
        if (start_i && (max_rx_count_i != '0)) begin
          patLatch_d = pattern_i;
          maxCnt_d   = max_rx_count_i;
          errCnt_d   = '0;
          bitCnt_d   = '0;
          shift_d    = '0;
          state_d    = HUNT;
        end
      end
      HUNT: begin
        if (bitValid_q) begin
          shift_d = shiftNext;
          if (shiftNext == patLatch_q) begin
            expIdx_d = IDX_MSB;
            state_d  = CHECK;
          end
        end
      end
      CHECK: begin
        if (bitCnt_q == maxCnt_q) begin
          quot_d   = numerator;
          rem_d    = '0;
          divCnt_d = '0;
          state_d  = DIVIDE;
        end else if (bitValid_q) begin
          bitCnt_d = bitCnt_q + CNT_W'(1);
          if (bitData_q != patLatch_q[expIdx_q]) begin
            errCnt_d = errCnt_q + CNT_W'(1);
          end
          expIdx_d = (expIdx_q == '0) ? IDX_MSB : expIdx_q - IDX_W'(1);
        end
      end
      DIVIDE: begin
        if (remShift >= {1'b0, maxCnt_q}) begin
          rem_d  = remShift[CNT_W-1:0] - maxCnt_q;
          quot_d = {quot_q[NUM_W-2:0], 1'b1};
        end else begin
          rem_d  = remShift[CNT_W-1:0];
          quot_d = {quot_q[NUM_W-2:0], 1'b0};
        end
        divCnt_d = divCnt_q + DC_W'(1);
        if (divCnt_q == DIV_LAST) begin
          state_d = SEND_HDR;
        end
      end
      SEND_HDR: begin
        if (to_uart_ready_i) begin
          state_d = SEND_PCT;
        end
      end
      SEND_PCT: begin
        if (to_uart_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      patLatch_q <= '0;
      shift_q    <= '0;
      maxCnt_q   <= '0;
      errCnt_q   <= '0;
      bitCnt_q   <= '0;
      expIdx_q   <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      divCnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      patLatch_q <= patLatch_d;
      shift_q    <= shift_d;
      maxCnt_q   <= maxCnt_d;
      errCnt_q   <= errCnt_d;
      bitCnt_q   <= bitCnt_d;
      expIdx_q   <= expIdx_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      divCnt_q   <= divCnt_d;
    end
  end

  assign busy_o            = (state_q != IDLE);
  assign rx_started_flag_o = state_q inside {CHECK, DIVIDE, SEND_HDR, SEND_PCT};
  assign bit_valid_o       = bitValid_q;
  assign bit_data_o        = bitData_q;
  assign err_count_o       = errCnt_q;
  assign to_uart_valid_o   = (state_q == SEND_HDR) || (state_q == SEND_PCT);
  assign to_uart_data_o    = (state_q == SEND_HDR) ? HDR_BYTE :
                             (state_q == SEND_PCT) ? quot_q[7:0] : 8'h00;

endmodule

// File: tb/tb_rx_ber_monitor.sv
// Self-checking bench for rx_ber_monitor: a continuous pattern transmitter, a per-cycle
// monitor against a stream/report model, and directed runs with hand-computed results.
module tb_rx_ber_monitor;

  localparam int OSR     = 10;
  localparam int PAT_W   = 8;
  localparam int CNT_W   = 20;
  localparam int HIST    = 60000;
  localparam int MAXBITS = 6000;

  logic             clk = 1'b0;
  logic             rst;
  logic             rxBitData;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] maxRxCount;
  logic             start;
  logic             busy;
  logic             rxStartedFlag;
  logic             bitValid;
  logic             bitData;
  logic [CNT_W-1:0] errCount;
  logic [7:0]       toUartData;
  logic             toUartValid;
  logic             toUartReady;

  int numCompared   = 0;
  int numMismatched = 0;

  rx_ber_monitor #(.OSR(OSR), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .rx_bit_data_i    (rxBitData),
    .pattern_i        (pattern),
    .max_rx_count_i   (maxRxCount),
    .start_i          (start),
    .busy_o           (busy),
    .rx_started_flag_o(rxStartedFlag),
    .bit_valid_o      (bitValid),
    .bit_data_o       (bitData),
    .err_count_o      (errCount),
    .to_uart_data_o   (toUartData),
    .to_uart_valid_o  (toUartValid),
    .to_uart_ready_i  (toUartReady)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numCompared++;
    if (actual !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Transmitter: the repeating reference pattern, MSB first, with optional inversions and period jitter.
  logic [7:0] txPattern = 8'hB4;
  bit         invertBit [MAXBITS];
  bit         jitterOn = 1'b0;
  int         txIdx = 0;
  int         curTxIdx = 0;

  initial begin
    int dur;
    rxBitData = 1'b0;
    @(posedge clk);
    #2;
    forever begin
      rxBitData = txPattern[7 - (txIdx % 8)] ^ invertBit[txIdx % MAXBITS];
      curTxIdx  = txIdx;
      dur = jitterOn ? 8 + int'($urandom_range(0, 4)) : OSR;
      repeat (dur) @(posedge clk);
      #2;
      txIdx++;
    end
  end

  // Line history as seen at each rising edge, for judging recovered bits.
  int   posCount = 0;
  bit   rxHist  [HIST];
  int   idxHist [HIST];
  logic rstAtEdge = 1'b0;

  always @(posedge clk) begin
    posCount                       <= posCount + 1;
    rxHist[(posCount + 1) % HIST]  <= rxBitData;
    idxHist[(posCount + 1) % HIST] <= curTxIdx;
    rstAtEdge                      <= rst;
  end

  logic [7:0] expQ [$];
  logic [7:0] capQ [$];
  int         prevRecIdx = -1;
  bit         holdPending = 1'b0;
  logic [7:0] holdData = 8'h00;

  always @(negedge clk) begin
    int t;
    logic [7:0] e;
    if (rstAtEdge) begin
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_flag", rxStartedFlag, 0);
      checkOutput("rst_bit_valid", bitValid, 0);
      checkOutput("rst_bit_data", bitData, 0);
      checkOutput("rst_err_count", errCount, 0);
      checkOutput("rst_uart_valid", toUartValid, 0);
      checkOutput("rst_uart_data", toUartData, 0);
      prevRecIdx  = -1;
      holdPending = 1'b0;
      expQ.delete();
    end else begin
      if (bitValid === 1'b1 && posCount >= 2) begin
        t = (posCount - 2) % HIST;
        checkOutput("bit_data", bitData, rxHist[t]);
        if (prevRecIdx >= 0) begin
          checkOutput("bit_sequence", idxHist[t], prevRecIdx + 1);
        end
        prevRecIdx = idxHist[t];
      end
      if (toUartValid === 1'b1) begin
        checkOutput("busy_while_valid", busy, 1);
        checkOutput("flag_while_valid", rxStartedFlag, 1);
      end
      if (holdPending) begin
        checkOutput("hold_valid", toUartValid, 1);
        checkOutput("hold_data", toUartData, holdData);
      end
      if (toUartValid === 1'b1 && toUartReady === 1'b1) begin
        holdPending = 1'b0;
        numCompared++;
        if (expQ.size() == 0) begin
          numMismatched++;
          $display("[TB] FAIL unexpected_byte: actual=%0h required=no byte", toUartData);
        end else begin
          e = expQ.pop_front();
          if (toUartData !== e) begin
            numMismatched++;
            $display("[TB] FAIL report_byte: actual=%0h required=%0h", toUartData, e);
          end
        end
        capQ.push_back(toUartData);
      end else if (toUartValid === 1'b1) begin
        holdPending = 1'b1;
        holdData    = toUartData;
      end else begin
        holdPending = 1'b0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] pat, input int maxCount);
    pattern    = pat;
    maxRxCount = CNT_W'(maxCount);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic launchRun(input int maxCount, input int expErr);
    expQ.push_back(8'hA5);
    expQ.push_back(8'(((maxCount - expErr) * 100) / maxCount));
    applyStimulus(txPattern, maxCount);
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) begin
      numCompared++;
      numMismatched++;
      $display("[TB] FAIL %s_timeout: actual=busy after %0d cycles required=idle", name, budget);
    end
  endtask

  task automatic runAndCheck(input string name, input int maxCount, input int expErr, input logic [7:0] litPct);
    int capBefore = capQ.size();
    launchRun(maxCount, expErr);
    waitIdle(name, (maxCount + 40) * 13 + 200);
    checkOutput({name, "_byte_count"}, capQ.size() - capBefore, 2);
    if (capQ.size() - capBefore == 2) begin
      checkOutput({name, "_hdr"}, capQ[capBefore], 8'hA5);
      checkOutput({name, "_pct"}, capQ[capBefore + 1], litPct);
    end
    checkOutput({name, "_err_count"}, errCount, expErr);
    checkOutput({name, "_idle_flag"}, rxStartedFlag, 0);
  endtask

  initial begin
    int base;
    int capBefore;
    int n;
    rst         = 1'b1;
    start       = 1'b0;
    pattern     = '0;
    maxRxCount  = '0;
    toUartReady = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    checkOutput("post_reset_busy", busy, 0);

    runAndCheck("steady", 1000, 0, 8'h64);

    base = txIdx;
    for (int k = 0; k < 50; k++) invertBit[(base + 30 + 15 * k) % MAXBITS] = 1'b1;
    runAndCheck("errors", 1000, 50, 8'h5F);

    $display("[TB] backpressure on the percentage byte");
    toUartReady = 1'b0;
    capBefore = capQ.size();
    launchRun(40, 0);
    n = 0;
    while (toUartValid !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    checkOutput("bp_hdr_valid", toUartValid, 1);
    toUartReady = 1'b1;
    tick();
    toUartReady = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("bp_pct_valid_held", toUartValid, 1);
    end
    checkOutput("bp_one_byte_so_far", capQ.size() - capBefore, 1);
    toUartReady = 1'b1;
    waitIdle("bp", 50);
    checkOutput("bp_byte_count", capQ.size() - capBefore, 2);
    if (capQ.size() - capBefore == 2) checkOutput("bp_pct", capQ[capBefore + 1], 8'h64);

    jitterOn = 1'b1;
    runAndCheck("jitter", 300, 0, 8'h64);
    jitterOn = 1'b0;

    applyStimulus(txPattern, 0);
    tick();
    checkOutput("max0_busy", busy, 0);
    checkOutput("max0_flag", rxStartedFlag, 0);
    base = txIdx;
    for (int k = 0; k < 4; k++) invertBit[(base + 20 + 5 * k) % MAXBITS] = 1'b1;
    capBefore = capQ.size();
    launchRun(100, 4);
    repeat (600) tick();
    checkOutput("midrun_flag", rxStartedFlag, 1);
    checkOutput("midrun_err_count", errCount, 4);
    applyStimulus(8'h0F, 5);
    tick();
    checkOutput("busy_start_ignored_busy", busy, 1);
    checkOutput("busy_start_ignored_err", errCount, 4);
    waitIdle("busy_start", 2000);
    checkOutput("busy_start_byte_count", capQ.size() - capBefore, 2);
    if (capQ.size() - capBefore == 2) checkOutput("busy_start_pct", capQ[capBefore + 1], 8'h60);
    checkOutput("busy_start_err_count", errCount, 4);

    $display("[TB] reset in the middle of a run");
    capBefore = capQ.size();
    applyStimulus(txPattern, 100);
    repeat (300) tick();
    checkOutput("prereset_flag", rxStartedFlag, 1);
    rst = 1'b1;
    tick();
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_flag", rxStartedFlag, 0);
    checkOutput("abort_uart_valid", toUartValid, 0);
    rst = 1'b0;
    repeat (1500) tick();
    checkOutput("abort_no_bytes", capQ.size() - capBefore, 0);
    checkOutput("abort_still_idle", busy, 0);
    runAndCheck("after_reset", 40, 0, 8'h64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: actual=still running required=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
